// File: rtl/usb_wb_pkg.sv
// Shared types and defaults for the USB core Wishbone arbiter.
package usb_wb_pkg;
  localparam int ADR_W_DEF = 30;
  localparam int DAT_W_DEF = 32;
  localparam int M_CPU     = 0;
  localparam int M_DBG     = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;
endpackage

// File: rtl/wb_timeout_counter.sv
// Bus watchdog: counts stalled strobe cycles, flags the terminal count.
module wb_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk48,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_cnt
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk48) begin
        if (reset || clear) cnt <= '0;
        else if (count_en)  cnt <= cnt + 1'b1;
      end

      // Terminal cycle is the TIMEOUT-th stalled cycle (count starts at 0).
      assign expired = (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/usb_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the USB core slave port.
module usb_wb_arbiter
  import usb_wb_pkg::*;
#(
  parameter int ADR_W   = ADR_W_DEF,
  parameter int DAT_W   = DAT_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk48,
  input  logic                   reset,
  input  logic [2*ADR_W-1:0]     m_adr,
  input  logic [2*DAT_W-1:0]     m_dat_w,
  input  logic [2*(DAT_W/8)-1:0] m_sel,
  input  logic [1:0]             m_we,
  input  logic [1:0]             m_cyc,
  input  logic [1:0]             m_stb,
  output logic [DAT_W-1:0]       m_dat_r,
  output logic [1:0]             m_ack,
  output logic [1:0]             m_err,
  output logic [ADR_W-1:0]       s_adr,
  output logic [DAT_W-1:0]       s_dat_w,
  output logic [DAT_W/8-1:0]     s_sel,
  output logic                   s_we,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic [2:0]             s_cti,
  output logic [1:0]             s_bte,
  input  logic [DAT_W-1:0]       s_dat_r,
  input  logic                   s_ack,
  input  logic                   s_err,
  output logic [1:0]             grant
);
  localparam int SEL_W = DAT_W / 8;

  arb_state_t state, state_nxt;
  logic [1:0] grant_nxt;
  logic       last_owner, last_nxt;
  logic       owner, own_cyc, own_stb, busy;
  logic       count_en, expired, timeout_err;

  assign owner   = grant[M_DBG];
  assign own_cyc = m_cyc[owner];
  assign own_stb = m_stb[owner];
  assign busy    = (state == BUSY);

  always_ff @(posedge clk48) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_owner <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_owner;
    case (state)
      IDLE: if (|m_cyc) begin
        state_nxt = BUSY;
        if (m_cyc == 2'b11) grant_nxt = last_owner ? 2'b01 : 2'b10;
        else                grant_nxt = m_cyc;
      end
      BUSY, ABORT: if (!own_cyc) begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
        last_nxt  = owner;
      end else if (busy && timeout_err) begin
        state_nxt = ABORT;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // Owner's request is passed through only while BUSY; ABORT and IDLE park the bus.
  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    if (busy) begin
      s_adr   = owner ? m_adr[2*ADR_W-1 -: ADR_W]   : m_adr[ADR_W-1:0];
      s_dat_w = owner ? m_dat_w[2*DAT_W-1 -: DAT_W] : m_dat_w[DAT_W-1:0];
      s_sel   = owner ? m_sel[2*SEL_W-1 -: SEL_W]   : m_sel[SEL_W-1:0];
      s_we    = m_we[owner];
    end
  end

  assign s_cyc   = busy && own_cyc;
  assign s_stb   = s_cyc && own_stb;
  assign s_cti   = 3'b000;
  assign s_bte   = 2'b00;
  assign m_dat_r = s_dat_r;

  assign count_en    = s_stb && !s_ack && !s_err;
  assign timeout_err = count_en && expired;

  wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk48    (clk48),
    .reset    (reset),
    .clear    (!count_en),
    .count_en (count_en),
    .expired  (expired)
  );

  always_comb begin
    m_ack = 2'b00;
    m_err = 2'b00;
    m_ack[owner] = busy && s_ack;
    m_err[owner] = busy && (s_err || timeout_err);
  end
endmodule

// File: tb/tb_usb_wb_arbiter.sv
// Directed self-checking bench for usb_wb_arbiter (watchdog TIMEOUT=8).
module tb_usb_wb_arbiter;
  localparam int ADR_W = 30;
  localparam int DAT_W = 32;

  logic                 clk48 = 1'b0;
  logic                 reset;
  logic [2*ADR_W-1:0]   m_adr;
  logic [2*DAT_W-1:0]   m_dat_w;
  logic [2*DAT_W/8-1:0] m_sel;
  logic [1:0]           m_we, m_cyc, m_stb;
  logic [DAT_W-1:0]     m_dat_r;
  logic [1:0]           m_ack, m_err;
  logic [ADR_W-1:0]     s_adr;
  logic [DAT_W-1:0]     s_dat_w;
  logic [DAT_W/8-1:0]   s_sel;
  logic                 s_we, s_cyc, s_stb;
  logic [2:0]           s_cti;
  logic [1:0]           s_bte;
  logic [DAT_W-1:0]     s_dat_r;
  logic                 s_ack, s_err;
  logic [1:0]           grant;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk48 = ~clk48;

  usb_wb_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(8)) dut (
    .clk48(clk48), .reset(reset),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_we(m_we),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .grant(grant)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk48);
    #1;
  endtask

  task automatic clear_inputs();
    m_adr = '0; m_dat_w = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    apply_reset();
    #1;
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rst_grant got %b exp 00", grant); end
    n_cmp++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin n_bad++; $display("FAIL rst_sctl got %b exp 000", {s_cyc, s_stb, s_we}); end
    n_cmp++; if ({m_ack, m_err} !== 4'b0000) begin n_bad++; $display("FAIL rst_resp got %b exp 0000", {m_ack, m_err}); end
    n_cmp++; if ({s_cti, s_bte} !== 5'b0) begin n_bad++; $display("FAIL rst_cti_bte got %b exp 00000", {s_cti, s_bte}); end
  endtask

  task automatic test_single_write();
    m_adr[ADR_W-1:0] = 30'h100; m_dat_w[DAT_W-1:0] = 32'hDEADBEEF; m_sel[3:0] = 4'hF;
    m_we = 2'b01; m_cyc = 2'b01; m_stb = 2'b01;
    #1;
    n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL t1_latency s_cyc got %b exp 0", s_cyc); end
    step();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL t1_grant got %b exp 01", grant); end
    n_cmp++; if (s_adr !== 30'h100) begin n_bad++; $display("FAIL t1_s_adr got %h exp 100", s_adr); end
    n_cmp++; if ({s_cyc, s_stb, s_we} !== 3'b111) begin n_bad++; $display("FAIL t1_sctl got %b exp 111", {s_cyc, s_stb, s_we}); end
    n_cmp++; if (s_dat_w !== 32'hDEADBEEF || s_sel !== 4'hF) begin n_bad++; $display("FAIL t1_wdata got %h/%h exp deadbeef/f", s_dat_w, s_sel); end
    n_cmp++; if (m_ack !== 2'b00) begin n_bad++; $display("FAIL t1_early_ack got %b exp 00", m_ack); end
    step();
    s_ack = 1'b1;
    #1;
    n_cmp++; if (m_ack !== 2'b01) begin n_bad++; $display("FAIL t1_ack got %b exp 01", m_ack); end
    step();
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    #1;
    n_cmp++; if (s_cyc !== 1'b0 || m_ack !== 2'b00) begin n_bad++; $display("FAIL t1_release got %b/%b exp 0/00", s_cyc, m_ack); end
    step();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL t1_idle got %b exp 00", grant); end
  endtask

  task automatic test_round_robin();
    clear_inputs();
    apply_reset();
    m_adr[2*ADR_W-1 -: ADR_W] = 30'h55;
    m_cyc = 2'b11;
    step();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL t2_first got %b exp 01", grant); end
    m_cyc = 2'b10;
    #1;
    n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL t2_drop_scyc got %b exp 0", s_cyc); end
    step();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL t2_gap got %b exp 00", grant); end
    step();
    n_cmp++; if (grant !== 2'b10 || s_adr !== 30'h55) begin n_bad++; $display("FAIL t2_second got %b/%h exp 10/55", grant, s_adr); end
    m_cyc = 2'b00;
    step();
    m_cyc = 2'b11;
    step();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL t2_third got %b exp 01", grant); end
    m_cyc = 2'b00;
    step();
  endtask

  task automatic test_burst_hold();
    logic [ADR_W-1:0] adrs [3];
    logic [DAT_W-1:0] dats [3];
    adrs = '{30'h10, 30'h14, 30'h18};
    dats = '{32'hA5A50001, 32'h12345678, 32'hFFFF0000};
    m_cyc = 2'b10;
    step();
    m_cyc = 2'b11; m_stb = 2'b10; m_we = 2'b00;
    for (int i = 0; i < 3; i++) begin
      m_adr[2*ADR_W-1 -: ADR_W] = adrs[i];
      s_dat_r = dats[i]; s_ack = 1'b1;
      #1;
      n_cmp++; if (grant !== 2'b10 || s_adr !== adrs[i]) begin n_bad++; $display("FAIL t3_hold%0d got %b/%h exp 10/%h", i, grant, s_adr, adrs[i]); end
      n_cmp++; if (m_ack !== 2'b10 || m_dat_r !== dats[i]) begin n_bad++; $display("FAIL t3_read%0d got %b/%h exp 10/%h", i, m_ack, m_dat_r, dats[i]); end
      step();
    end
    s_ack = 1'b0; m_stb = 2'b00; m_cyc = 2'b01;
    step();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL t3_gap got %b exp 00", grant); end
    step();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL t3_m0_grant got %b exp 01", grant); end
    m_cyc = 2'b00;
    step();
  endtask

  task automatic test_timeout();
    m_adr[ADR_W-1:0] = 30'h200; m_we = 2'b00; m_cyc = 2'b01; m_stb = 2'b01;
    step();
    for (int k = 1; k <= 8; k++) begin
      #1;
      n_cmp++; if (m_err !== ((k == 8) ? 2'b01 : 2'b00)) begin n_bad++; $display("FAIL t4_err_cyc%0d got %b exp %b", k, m_err, (k == 8) ? 2'b01 : 2'b00); end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      s_ack = (k == 1);
      #1;
      n_cmp++; if ({s_cyc, s_stb, m_err, m_ack} !== 6'b0) begin n_bad++; $display("FAIL t4_abort%0d got %b exp 000000", k, {s_cyc, s_stb, m_err, m_ack}); end
      step();
    end
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    step();
    m_cyc = 2'b10;
    step();
    n_cmp++; if (grant !== 2'b10 || s_cyc !== 1'b1) begin n_bad++; $display("FAIL t4_recover got %b/%b exp 10/1", grant, s_cyc); end
    m_cyc = 2'b00;
    step();
  endtask

  task automatic test_ack_at_terminal();
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    for (int k = 1; k < 8; k++) step();
    s_ack = 1'b1;
    #1;
    n_cmp++; if (m_ack !== 2'b01 || m_err !== 2'b00) begin n_bad++; $display("FAIL t5_term got %b/%b exp 01/00", m_ack, m_err); end
    step();
    s_ack = 1'b0; m_stb = 2'b00;
    #1;
    n_cmp++; if (grant !== 2'b01 || s_cyc !== 1'b1 || m_err !== 2'b00) begin n_bad++; $display("FAIL t5_busy got %b/%b/%b exp 01/1/00", grant, s_cyc, m_err); end
    m_cyc = 2'b00;
    step();
  endtask

  task automatic test_reset_mid();
    m_cyc = 2'b10; m_stb = 2'b10;
    step();
    n_cmp++; if (s_stb !== 1'b1) begin n_bad++; $display("FAIL t6_pending got %b exp 1", s_stb); end
    reset = 1'b1;
    step();
    s_ack = 1'b1;
    #1;
    n_cmp++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin n_bad++; $display("FAIL t6_rst got %b/%b exp 00/0", grant, s_cyc); end
    n_cmp++; if (m_ack !== 2'b00 || m_err !== 2'b00) begin n_bad++; $display("FAIL t6_rst_resp got %b/%b exp 00/00", m_ack, m_err); end
    reset = 1'b0; s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    step();
    m_cyc = 2'b10;
    #1;
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL t6_latency got %b exp 00", grant); end
    step();
    n_cmp++; if (grant !== 2'b10 || s_cyc !== 1'b1) begin n_bad++; $display("FAIL t6_regrant got %b/%b exp 10/1", grant, s_cyc); end
    m_cyc = 2'b00;
    step();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_burst_hold();
    test_timeout();
    test_ack_at_terminal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
